// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: shared pipeline constants and wait-state FSM encoding
package hazard_stall_unit_pkg;
   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
   localparam int SRAM_WAIT_DEF = 4;
   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} wait_state_t;
endpackage

// File: rtl/hazard_stall_unit_sram_wait.sv
// sram_wait_fsm: holds the pipeline for SRAM_WAIT cycles per MEM-stage access
module sram_wait_fsm
   import hazard_stall_unit_pkg::*;
#(
   parameter int SRAM_WAIT = SRAM_WAIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic mem_access,
   output logic mem_busy,
   output logic mem_ready
);
   localparam logic [3:0] SW = 4'(SRAM_WAIT);
   localparam logic HAS_WAIT = SRAM_WAIT > 0;
   wait_state_t state;
   logic [3:0] cnt;
   // State and wait counter; any cnt at or past SW leaves WAIT
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt <= 4'd0;
      end else if (state == IDLE) begin
         if (mem_access && HAS_WAIT) begin
            state <= WAIT;
            cnt <= 4'd1;
         end
      end else if (cnt >= SW) begin
         state <= IDLE;
         cnt <= 4'd0;
      end else begin
         cnt <= cnt + 4'd1;
      end
   end
   // Busy until the last wait cycle; ready when the access sits unfrozen in MEM
   always_comb begin
      mem_busy = ~rst & ((state == IDLE) ? (mem_access & HAS_WAIT) : (cnt != SW));
      mem_ready = ~rst & mem_access & ~mem_busy;
   end
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: RAW stall/bubble control plus SRAM wait freeze; FORWARDING_EN limits stalls to load-use
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int SRAM_WAIT = SRAM_WAIT_DEF,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] src1_ID,
   input  logic [REG_W-1:0] src2_ID,
   input  logic             two_src_ID,
   input  logic [REG_W-1:0] dest_EXE,
   input  logic             WB_EN_EXE,
   input  logic             MEM_R_EN_EXE,
   input  logic [REG_W-1:0] dest_MEM,
   input  logic             WB_EN_MEM,
   input  logic             MEM_R_EN_MEM,
   input  logic             MEM_W_EN_MEM,
   output logic             freeze_IF,
   output logic             freeze_ID,
   output logic             bubble_EXE,
   output logic             freeze_EXE_MEM,
   output logic             mem_ready,
   output logic [CNT_W-1:0] stall_count
);
   logic hit_exe, hit_mem, data_hazard, mem_busy;
   sram_wait_fsm #(.SRAM_WAIT(SRAM_WAIT)) u_wait (
      .clk(clk),
      .rst(rst),
      .mem_access(MEM_R_EN_MEM | MEM_W_EN_MEM),
      .mem_busy(mem_busy),
      .mem_ready(mem_ready)
   );
   // Source/destination match against EXE and MEM producers; r0 never hazards
   always_comb begin
      hit_exe = WB_EN_EXE & (dest_EXE != REG_ZERO) & ((src1_ID == dest_EXE) | (two_src_ID & (src2_ID == dest_EXE)));
      hit_mem = WB_EN_MEM & (dest_MEM != REG_ZERO) & ((src1_ID == dest_MEM) | (two_src_ID & (src2_ID == dest_MEM)));
`ifdef FORWARDING_EN
      data_hazard = ~rst & hit_exe & MEM_R_EN_EXE;
`else
      data_hazard = ~rst & (hit_exe | hit_mem);
`endif
      freeze_EXE_MEM = mem_busy;
      freeze_ID = mem_busy;
      freeze_IF = mem_busy | data_hazard;
      bubble_EXE = data_hazard & ~mem_busy;
   end
   // Saturating count of front-end stall cycles
   always_ff @(posedge clk) begin
      if (rst) stall_count <= '0;
      else if (freeze_IF && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
   end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed checks of hazard stalls, SRAM wait freeze and stall counter
module tb_hazard_stall_unit;
   logic clk = 0, rst = 1;
   logic [4:0] src1_ID, src2_ID, dest_EXE, dest_MEM;
   logic two_src_ID, WB_EN_EXE, MEM_R_EN_EXE, WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM;
   logic freeze_IF, freeze_ID, bubble_EXE, freeze_EXE_MEM, mem_ready;
   logic [15:0] stall_count;
   logic [4:0] o;
   int total = 0, bad = 0;
`ifdef FORWARDING_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif
   hazard_stall_unit #(.SRAM_WAIT(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .src1_ID(src1_ID), .src2_ID(src2_ID), .two_src_ID(two_src_ID),
      .dest_EXE(dest_EXE), .WB_EN_EXE(WB_EN_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE),
      .dest_MEM(dest_MEM), .WB_EN_MEM(WB_EN_MEM), .MEM_R_EN_MEM(MEM_R_EN_MEM), .MEM_W_EN_MEM(MEM_W_EN_MEM),
      .freeze_IF(freeze_IF), .freeze_ID(freeze_ID), .bubble_EXE(bubble_EXE),
      .freeze_EXE_MEM(freeze_EXE_MEM), .mem_ready(mem_ready), .stall_count(stall_count)
   );
   always #5 clk = ~clk;
   assign o = {freeze_IF, freeze_ID, bubble_EXE, freeze_EXE_MEM, mem_ready};
   task automatic clr();
      src1_ID = 0; src2_ID = 0; two_src_ID = 0; dest_EXE = 0; WB_EN_EXE = 0; MEM_R_EN_EXE = 0;
      dest_MEM = 0; WB_EN_MEM = 0; MEM_R_EN_MEM = 0; MEM_W_EN_MEM = 0;
   endtask
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      clr();
      rst = 1;
      nxt();
      rst = 0;
      #1;
   endtask
   task automatic test_reset();
      clr();
      rst = 1;
      src1_ID = 5; dest_EXE = 5; WB_EN_EXE = 1; MEM_R_EN_EXE = 1; MEM_W_EN_MEM = 1;
      nxt();
      nxt();
      #1;
      total++;
      if (o !== 5'b00000) begin bad++; $display("FAIL reset_outputs got=%b want=00000", o); end
      total++;
      if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", stall_count); end
      clr();
      rst = 0;
      nxt();
   endtask
   task automatic test_load_use();
      do_reset();
      src1_ID = 5; dest_EXE = 5; WB_EN_EXE = 1; MEM_R_EN_EXE = 1;
      #1;
      total++;
      if (o !== 5'b10100) begin bad++; $display("FAIL load_use got=%b want=10100", o); end
      total++;
      if (stall_count !== 16'd0) begin bad++; $display("FAIL load_use_cnt0 got=%0d want=0", stall_count); end
      nxt();
      clr();
      #1;
      total++;
      if (o !== 5'b00000) begin bad++; $display("FAIL load_use_release got=%b want=00000", o); end
      total++;
      if (stall_count !== 16'd1) begin bad++; $display("FAIL load_use_cnt1 got=%0d want=1", stall_count); end
   endtask
   task automatic test_alu_raw();
      logic [4:0] exp;
      do_reset();
      exp = FWD ? 5'b00000 : 5'b10100;
      src1_ID = 3; src2_ID = 7; two_src_ID = 1; dest_EXE = 7; WB_EN_EXE = 1;
      #1;
      total++;
      if (o !== exp) begin bad++; $display("FAIL alu_raw_exe got=%b want=%b", o, exp); end
      dest_EXE = 0; WB_EN_EXE = 0; dest_MEM = 7; WB_EN_MEM = 1;
      #1;
      total++;
      if (o !== exp) begin bad++; $display("FAIL alu_raw_mem got=%b want=%b", o, exp); end
      clr();
   endtask
   task automatic test_masking();
      do_reset();
      src1_ID = 0; dest_EXE = 0; WB_EN_EXE = 1; MEM_R_EN_EXE = 1; dest_MEM = 0; WB_EN_MEM = 1;
      #1;
      total++;
      if (o !== 5'b00000) begin bad++; $display("FAIL r0_mask got=%b want=00000", o); end
      clr();
      src1_ID = 3; src2_ID = 5; two_src_ID = 0; dest_EXE = 5; WB_EN_EXE = 1; MEM_R_EN_EXE = 1;
      dest_MEM = 5; WB_EN_MEM = 1;
      #1;
      total++;
      if (o !== 5'b00000) begin bad++; $display("FAIL src2_mask got=%b want=00000", o); end
      two_src_ID = 1;
      #1;
      total++;
      if (o !== 5'b10100) begin bad++; $display("FAIL src2_hit got=%b want=10100", o); end
      clr();
   endtask
   task automatic test_sram_wait();
      logic [4:0] exp;
      do_reset();
      MEM_W_EN_MEM = 1;
      for (int i = 0; i < 10; i++) begin
         #1;
         exp = ((i % 5) < 4) ? 5'b11010 : 5'b00001;
         total++;
         if (o !== exp) begin bad++; $display("FAIL sram_wait cyc=%0d got=%b want=%b", i, o, exp); end
         nxt();
      end
      clr();
      #1;
      total++;
      if (stall_count !== 16'd8) begin bad++; $display("FAIL sram_wait_cnt got=%0d want=8", stall_count); end
   endtask
   task automatic test_overlap();
      logic [4:0] exp;
      do_reset();
      src1_ID = 5; dest_EXE = 5; WB_EN_EXE = 1; MEM_R_EN_EXE = 1;
      dest_MEM = 9; WB_EN_MEM = 1; MEM_R_EN_MEM = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         exp = (i < 4) ? 5'b11010 : 5'b10101;
         total++;
         if (o !== exp) begin bad++; $display("FAIL overlap cyc=%0d got=%b want=%b", i, o, exp); end
         nxt();
      end
      clr();
      #1;
      total++;
      if (o !== 5'b00000) begin bad++; $display("FAIL overlap_release got=%b want=00000", o); end
   endtask
   task automatic test_reset_mid_wait();
      logic [4:0] exp;
      do_reset();
      MEM_W_EN_MEM = 1;
      nxt();
      nxt();
      rst = 1;
      #1;
      total++;
      if (o !== 5'b00000) begin bad++; $display("FAIL rst_mid_wait_out got=%b want=00000", o); end
      nxt();
      rst = 0;
      clr();
      #1;
      total++;
      if (o !== 5'b00000) begin bad++; $display("FAIL rst_mid_wait_idle got=%b want=00000", o); end
      total++;
      if (stall_count !== 16'd0) begin bad++; $display("FAIL rst_mid_wait_cnt got=%0d want=0", stall_count); end
      MEM_W_EN_MEM = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         exp = (i < 4) ? 5'b11010 : 5'b00001;
         total++;
         if (o !== exp) begin bad++; $display("FAIL rst_reentry cyc=%0d got=%b want=%b", i, o, exp); end
         nxt();
      end
      clr();
   endtask
   task automatic test_saturation();
      do_reset();
      src1_ID = 5; dest_EXE = 5; WB_EN_EXE = 1; MEM_R_EN_EXE = 1;
      repeat (65534) @(posedge clk);
      #1;
      total++;
      if (stall_count !== 16'd65534) begin bad++; $display("FAIL sat_pre got=%0d want=65534", stall_count); end
      @(posedge clk);
      #1;
      total++;
      if (stall_count !== 16'd65535) begin bad++; $display("FAIL sat_max got=%0d want=65535", stall_count); end
      repeat (4465) @(posedge clk);
      #1;
      total++;
      if (stall_count !== 16'd65535) begin bad++; $display("FAIL sat_hold got=%0d want=65535", stall_count); end
      clr();
   endtask
   initial begin
      clr();
      test_reset();
      test_load_use();
      test_alu_raw();
      test_masking();
      test_sram_wait();
      test_overlap();
      test_reset_mid_wait();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
